ex_operand_stage: RTL and testbench
===================================

# ex_operand_stage

ID/EX pipeline stage of the 32-bit MIPS-lite core, sitting directly upstream of the ALU. It latches decoded operands and control from the decode stage and applies EX/MEM and MEM/WB forwarding to the operands. It then drives the ALU `a`, `b` and `alu_control` inputs, plus the store-data and control fields carried to MEM. It also detects load-use hazards and inserts the required one-cycle bubble.

## Interface
Parameters
- `DW`, 32: datapath width.
- `RW`, 5: register-index width.

Ports
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `id_valid` in 1: decode stage holds a real instruction.
- `id_rs_data`, `id_rt_data` in DW: register-file read data.
- `id_imm` in DW: immediate, already sign-extended.
- `id_rs`, `id_rt`, `id_rd` in RW: source and destination indices.
- `id_alu_src` in 1: 1 selects `id_imm` as operand B.
- `id_reg_dst` in 1: 1 selects `rd`, 0 selects `rt` as destination.
- `id_alu_control` in 3: ALU operation code.
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg` in 1: control bits.
- `stall` in 1: hold the stage (external, e.g. memory wait).
- `flush` in 1: replace the stage contents with a bubble (branch/jump taken).
- `exmem_reg_write` in 1, `exmem_rd` in RW, `exmem_result` in DW: EX/MEM forwarding source.
- `memwb_reg_write` in 1, `memwb_rd` in RW, `memwb_result` in DW: MEM/WB forwarding source.
- `ex_a`, `ex_b` out DW: ALU operands.
- `ex_alu_control` out 3: ALU operation code.
- `ex_store_data` out DW: forwarded `rt` value for stores.
- `ex_dest` out RW: destination register index.
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg` out 1: stage valid and control outputs.
- `load_use_stall` out 1: request to the hazard unit to hold PC and IF/ID.

## Operation
- Stage register contents: `valid`, `rs_data`, `rt_data`, `imm`, `rs`, `rt`, `dest`, `alu_src`, `alu_control`, and the four control bits.
- `dest` is resolved at capture time as `id_reg_dst ? id_rd : id_rt`.
- Load-use detect (combinational): `load_use_stall = valid & mem_read & dest!=0 & id_valid & (dest==id_rs | dest==id_rt)`.
- Update priority at each clock edge:
  1. `flush`: load a bubble.
  2. `stall`: hold all contents.
  3. `load_use_stall`: load a bubble.
  4. Otherwise: capture the ID inputs.
- A bubble sets `valid=0`, clears all control bits, sets `alu_control=3'b000`, and clears all data and index fields.
- Forwarding per source operand (applies to `rs` and to `rt`):
  - EX/MEM is selected if `exmem_reg_write` is set, `exmem_rd!=0` and `exmem_rd` equals the index.
  - Otherwise MEM/WB is selected under the same conditions using `memwb_*`.
  - Otherwise the latched register-file data is used.
  - EX/MEM always wins over MEM/WB.
  - Register 0 is never forwarded.
- Output derivation:
  - `ex_a` = forwarded `rs`.
  - `ex_store_data` = forwarded `rt`.
  - `ex_b` = `alu_src ? imm : forwarded rt`.
- Control outputs are gated by `valid`. `ex_alu_control` passes through ungated; downstream logic ignores it when `ex_valid=0`.
- Data moves unmodified: no width change and no arithmetic in this block.

## Timing
- Latency: one cycle from the ID inputs to the latched fields.
- `ex_a`, `ex_b` and `ex_store_data` are combinational from the latched fields and the current-cycle forwarding inputs.
- `load_use_stall` is combinational and valid in the same cycle as the offending ID inputs.
- It deasserts the cycle after the bubble is inserted, because the load has then moved to MEM.
- Values while `reset` is asserted (asynchronous):
  - All latched fields are 0.
  - `ex_valid` and all control outputs are 0.
  - `ex_alu_control=3'b000` and `ex_dest=0`.
  - `ex_a`, `ex_b` and `ex_store_data` are 0, because index 0 is never forwarded.
  - `load_use_stall=0`.
- Reset deassertion mid-instruction: the stage restarts with a bubble, and the first capture happens on the next edge without stall or flush.
- Simultaneous events:
  - `flush` with `stall`: flush wins.
  - `stall` with a load-use hazard: hold wins, and `load_use_stall` stays asserted until the hold ends.
- Holding with `stall` re-evaluates forwarding every cycle. The held operands therefore track newly arriving EX/MEM and MEM/WB results.

## Structure
- Shared package `mips_pkg`:
  - ALU operation codes: ADD 010, SUB 110, SLT 111, AND 000, OR 001, XOR 011, NOR 100.
  - Forward-select encoding: FWD_NONE, FWD_EXMEM, FWD_MEMWB.
  - Constant `REG_ZERO`.
- One sub-module, `fwd_mux`: takes an index, the latched data and both forwarding sources, and returns the forwarded value. It is instantiated twice, once for `rs` and once for `rt`.

## Test plan
- **Reset.** Assert `reset` mid-run → all outputs 0 and `ex_valid=0` immediately. After release, `id_rs_data=5`, `id_rt_data=7`, `id_alu_control=010` → next cycle `ex_a=5`, `ex_b=7`, `ex_valid=1`.
- **Forwarding priority.** Latched `rs=3`. `exmem_rd=3`/`exmem_result=0xAA` and `memwb_rd=3`/`memwb_result=0xBB`, both with write set → `ex_a=0xAA`. Drop `exmem_reg_write` → `ex_a=0xBB`. Use index 0 with both sources matching → `ex_a` equals the latched value.
- **Immediate select.** `id_alu_src=1`, `id_imm=0xFFFFFFFC`, `rt` forwarded as 0x10 → `ex_b=0xFFFFFFFC` and `ex_store_data=0x10`.
- **Load-use.** A `lw` to `$4` sits in the stage and the next ID instruction uses `rs=4` → `load_use_stall=1` for one cycle, a bubble is inserted (`ex_valid=0`), and the dependent instruction is captured on the following edge.
- **Flush vs stall.** `flush` and `stall` asserted together → a bubble is loaded. `stall` alone for 3 cycles → contents are held and `ex_valid` is unchanged.
- **Register-0 destination.** `lw` to `$0` followed by a use of `$0` → `load_use_stall` stays 0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: ALU opcodes, forward-select encoding and shared constants for the MIPS-lite core
package mips_pkg;
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_XOR = 3'b011,
    ALU_NOR = 3'b100,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_t;
  typedef enum logic [1:0] {
    FWD_NONE  = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;
  localparam int REG_ZERO = 0;
endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: picks EX/MEM, then MEM/WB, then latched data for one source operand
module fwd_mux
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic [RW-1:0] idx,
  input  logic [DW-1:0] rf_data,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic [DW-1:0] data
);
  fwd_sel_t sel;
  always_comb begin
    sel = (exmem_reg_write && exmem_rd != RW'(REG_ZERO) && exmem_rd == idx) ? FWD_EXMEM :
          (memwb_reg_write && memwb_rd != RW'(REG_ZERO) && memwb_rd == idx) ? FWD_MEMWB : FWD_NONE;
    data = sel == FWD_EXMEM ? exmem_result : sel == FWD_MEMWB ? memwb_result : rf_data;
  end
endmodule

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX register with operand forwarding and load-use bubble insertion
module ex_operand_stage
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          id_alu_src,
  input  logic          id_reg_dst,
  input  logic [2:0]    id_alu_control,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          stall,
  input  logic          flush,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [2:0]    ex_alu_control,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_dest,
  output logic          ex_valid,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg,
  output logic          load_use_stall
);
  typedef struct packed {
    logic          valid;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] dest;
    logic          alu_src;
    logic [2:0]    alu_control;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
  } stage_t;
  stage_t st, nxt;
  logic [DW-1:0] fwd_rs, fwd_rt;
  always_comb begin
    load_use_stall = st.valid && st.mem_read && st.dest != RW'(REG_ZERO) && id_valid &&
                     (st.dest == id_rs || st.dest == id_rt);
    nxt = (flush || load_use_stall) ? '0 : stage_t'{
      valid: id_valid, rs_data: id_rs_data, rt_data: id_rt_data, imm: id_imm,
      rs: id_rs, rt: id_rt, dest: id_reg_dst ? id_rd : id_rt, alu_src: id_alu_src,
      alu_control: id_alu_control, reg_write: id_reg_write, mem_read: id_mem_read,
      mem_write: id_mem_write, mem_to_reg: id_mem_to_reg};
  end
  // flush overrides stall; a stalled load-use hazard simply holds
  always_ff @(posedge clk or posedge reset)
    if (reset) st <= '0;
    else if (flush || !stall) st <= nxt;
  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
    .idx(st.rs), .rf_data(st.rs_data),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .data(fwd_rs)
  );
  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
    .idx(st.rt), .rf_data(st.rt_data),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .data(fwd_rt)
  );
  always_comb begin
    ex_a           = fwd_rs;
    ex_store_data  = fwd_rt;
    ex_b           = st.alu_src ? st.imm : fwd_rt;
    ex_alu_control = st.alu_control;
    ex_dest        = st.dest;
    ex_valid       = st.valid;
    ex_reg_write   = st.valid && st.reg_write;
    ex_mem_read    = st.valid && st.mem_read;
    ex_mem_write   = st.valid && st.mem_write;
    ex_mem_to_reg  = st.valid && st.mem_to_reg;
  end
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed vectors with hand-computed expectations for ex_operand_stage
module tb_ex_operand_stage;
  logic        clk = 0, reset = 1;
  logic        id_valid, id_alu_src, id_reg_dst;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [2:0]  id_alu_control;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        stall, flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [2:0]  ex_alu_control;
  logic [4:0]  ex_dest;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, load_use_stall;
  int n_cmp = 0, n_err = 0;

  ex_operand_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_src(id_alu_src),
    .id_reg_dst(id_reg_dst), .id_alu_control(id_alu_control), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .stall(stall), .flush(flush), .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .memwb_result(memwb_result), .ex_a(ex_a), .ex_b(ex_b), .ex_alu_control(ex_alu_control),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_clear();
    id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_alu_src = 0; id_reg_dst = 0; id_alu_control = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
  endtask

  task automatic fwd_clear();
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic id_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] rsd, input logic [31:0] rtd);
    id_clear();
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd; id_rt_data = rtd;
    id_reg_dst = 1; id_alu_control = 3'b010; id_reg_write = 1;
  endtask

  task automatic id_lw(input logic [4:0] rs, input logic [4:0] rt);
    id_clear();
    id_valid = 1; id_rs = rs; id_rt = rt; id_imm = 32'd8; id_alu_src = 1;
    id_alu_control = 3'b010; id_reg_write = 1; id_mem_read = 1; id_mem_to_reg = 1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, {31'd0, ex_valid}, 0);
    check({tag, "_a"}, ex_a, 0);
    check({tag, "_b"}, ex_b, 0);
    check({tag, "_sd"}, ex_store_data, 0);
    check({tag, "_dest"}, {27'd0, ex_dest}, 0);
    check({tag, "_ctl"}, {29'd0, ex_alu_control}, 0);
    check({tag, "_ctrl"}, {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 0);
    check({tag, "_lus"}, {31'd0, load_use_stall}, 0);
  endtask

  initial begin
    id_clear(); fwd_clear(); stall = 0; flush = 0;
    tick(); tick();
    check_zero("rst");
    reset = 0;
    id_add(5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
    tick();
    check("cap_a", ex_a, 5);
    check("cap_b", ex_b, 7);
    check("cap_valid", {31'd0, ex_valid}, 1);
    check("cap_dest", {27'd0, ex_dest}, 3);
    check("cap_rw", {31'd0, ex_reg_write}, 1);
    // asynchronous reset between edges
    #2 reset = 1;
    #1 check_zero("arst");
    tick();
    #2 reset = 0;
    tick();
    check("post_rst_a", ex_a, 5);
    check("post_rst_b", ex_b, 7);
    check("post_rst_valid", {31'd0, ex_valid}, 1);
    check("post_rst_ctl", {29'd0, ex_alu_control}, 3'b010);
    // forwarding priority
    id_add(5'd3, 5'd5, 5'd9, 32'h33, 32'h55);
    tick();
    id_clear();
    exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'hAA;
    memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'hBB;
    #1 check("fwd_exmem", ex_a, 32'hAA);
    check("fwd_exmem_rt", ex_b, 32'h55);
    exmem_reg_write = 0;
    #1 check("fwd_memwb", ex_a, 32'hBB);
    memwb_rd = 5;
    #1 check("fwd_none_a", ex_a, 32'h33);
    check("fwd_rt_b", ex_b, 32'hBB);
    check("fwd_rt_sd", ex_store_data, 32'hBB);
    fwd_clear();
    id_add(5'd0, 5'd0, 5'd9, 32'h99, 32'h66);
    tick();
    exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hAA;
    memwb_reg_write = 1; memwb_rd = 0; memwb_result = 32'hBB;
    #1 check("fwd_r0_a", ex_a, 32'h99);
    check("fwd_r0_sd", ex_store_data, 32'h66);
    fwd_clear();
    // immediate select with forwarded store data
    id_clear();
    id_valid = 1; id_rs = 1; id_rt = 6; id_rs_data = 32'h100; id_rt_data = 32'h1;
    id_imm = 32'hFFFF_FFFC; id_alu_src = 1; id_mem_write = 1;
    tick();
    exmem_reg_write = 1; exmem_rd = 6; exmem_result = 32'h10;
    #1 check("imm_b", ex_b, 32'hFFFF_FFFC);
    check("imm_sd", ex_store_data, 32'h10);
    check("imm_a", ex_a, 32'h100);
    check("imm_mw", {31'd0, ex_mem_write}, 1);
    fwd_clear();
    // load-use bubble
    id_lw(5'd1, 5'd4);
    tick();
    id_add(5'd4, 5'd2, 5'd7, 32'h44, 32'h22);
    #1 check("lu_stall", {31'd0, load_use_stall}, 1);
    check("lu_mr", {31'd0, ex_mem_read}, 1);
    check("lu_dest", {27'd0, ex_dest}, 4);
    tick();
    check("lu_bubble_valid", {31'd0, ex_valid}, 0);
    check("lu_bubble_stall", {31'd0, load_use_stall}, 0);
    check("lu_bubble_dest", {27'd0, ex_dest}, 0);
    tick();
    check("lu_dep_valid", {31'd0, ex_valid}, 1);
    check("lu_dep_dest", {27'd0, ex_dest}, 7);
    check("lu_dep_a", ex_a, 32'h44);
    // stall with load-use hazard holds the load
    id_lw(5'd1, 5'd8);
    tick();
    id_add(5'd2, 5'd8, 5'd9, 32'h2, 32'h8);
    stall = 1;
    tick();
    check("lus_hold_stall", {31'd0, load_use_stall}, 1);
    check("lus_hold_mr", {31'd0, ex_mem_read}, 1);
    stall = 0;
    tick();
    check("lus_bubble", {31'd0, ex_valid}, 0);
    // flush with stall loads a bubble
    tick();
    check("fs_pre_valid", {31'd0, ex_valid}, 1);
    stall = 1; flush = 1;
    tick();
    check("fs_bubble", {31'd0, ex_valid}, 0);
    stall = 0; flush = 0;
    id_add(5'd1, 5'd2, 5'd3, 32'h77, 32'h78);
    tick();
    stall = 1;
    id_add(5'd1, 5'd2, 5'd3, 32'h12, 32'h13);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_valid", {31'd0, ex_valid}, 1);
      check("hold_a", ex_a, 32'h77);
    end
    memwb_reg_write = 1; memwb_rd = 1; memwb_result = 32'hC0;
    #1 check("hold_fwd_a", ex_a, 32'hC0);
    fwd_clear();
    stall = 0;
    tick();
    check("release_a", ex_a, 32'h12);
    // load to $0 never stalls
    id_lw(5'd1, 5'd0);
    tick();
    id_add(5'd0, 5'd0, 5'd5, 32'h3, 32'h4);
    #1 check("r0_lus", {31'd0, load_use_stall}, 0);
    tick();
    check("r0_valid", {31'd0, ex_valid}, 1);
    check("r0_dest", {27'd0, ex_dest}, 5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
